decode_queue: RTL
=================

Name: decode_queue

Overview:
Parametrised successor to the single-issue decode stage. It sits between fetch and rename/dispatch.
- Buffers fetched instructions with their PCs in a circular queue.
- Presents up to DEC_WIDTH oldest entries per cycle as fully decoded RV32I slots.
- Retires whatever prefix rename accepts.
- Decouples fetch from back-end stalls and supports a single-cycle flush.

Parameters:
DEPTH, 8, queue entries; power of two, >= DEC_WIDTH, >= 2
DEC_WIDTH, 2, decode slots presented per cycle; 1..4
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)
DCW, $clog2(DEC_WIDTH+1), dispatch count width (derived)

Ports:
clk  input  1  clock; all state on posedge
rst  input  1  synchronous active-high reset
flush  input  1  discard all entries (mispredict/redirect)
enq_valid  input  1  fetch presents an instruction
enq_inst  input  32  instruction word
enq_pc  input  32  PC of enq_inst
enq_ready  output  1  queue can accept this cycle
deq_cnt  input  DCW  number of head slots consumed by rename this cycle
out_valid  output  DEC_WIDTH  slot i holds a valid decoded instruction
out_pc  output  32*DEC_WIDTH  PC per slot
out_opcode  output  7*DEC_WIDTH  inst[6:0]
out_funct3  output  3*DEC_WIDTH  inst[14:12]
out_funct7  output  7*DEC_WIDTH  inst[31:25]
out_rs1  output  5*DEC_WIDTH  inst[19:15]
out_rs2  output  5*DEC_WIDTH  inst[24:20]
out_rd  output  5*DEC_WIDTH  inst[11:7]
out_imm  output  32*DEC_WIDTH  selected immediate
out_regf_we  output  DEC_WIDTH  slot writes an architectural register
out_illegal  output  DEC_WIDTH  unsupported opcode (see Optional Feature)
occupancy  output  CNT_W  current entry count

Behaviour:
- Clocking and reset: one clock (clk), synchronous active-high reset (rst). On rst: head=0, tail=0, count=0.
  - occupancy=0, out_valid=0, enq_ready=1.
  - Entry storage is not cleared.
- enq_ready = (count < DEPTH). It does not depend on same-cycle dequeue.
- Enqueue fires when enq_valid && enq_ready && !flush.
  - Entry[tail] <= {enq_inst, enq_pc}; tail increments modulo DEPTH.
- Slot i (0..DEC_WIDTH-1) reads entry[(head+i) mod DEPTH]. out_valid[i] = (i < count).
- All slot outputs are combinational from stored entries.
  - Enqueue-to-visible latency is 1 cycle; no bypass of enq_inst.
- When out_valid[i]=0, all fields of slot i are 0.
- Dequeue: rename drives deq_cnt <= popcount(out_valid), in-order prefix only.
  - head advances by deq_cnt modulo DEPTH.
  - deq_cnt > number of valid slots is illegal; the assertion fires.
- count_next = count + enq_fire - deq_cnt. Simultaneous enqueue and dequeue at full or empty are handled exactly by this rule.
- Flush has priority over enq and deq in the same cycle: head=tail=count=0 next cycle. enq_ready is unaffected during the flush cycle.
- Pointer wrap: tail and head wrap from DEPTH-1 to 0. Multi-slot reads wrap across the end of storage.
- Immediate selection by opcode:
  - lui/auipc(0110111/0010111): U.
  - jal(1101111): J.
  - jalr(1100111), load(0000011), op_imm(0010011): I.
  - br(1100011): B.
  - store(0100011): S.
  - otherwise 0.
  - Sign extension from inst[31]; B and J have bit0=0.
- out_regf_we = 1 for lui, auipc, jal, jalr, load, op_imm, op_reg(0110011), only when rd != 0; else 0.

Optional Feature:
DECODE_ILLEGAL_EN:
- Defined: out_illegal[i]=1 when valid and the opcode is not one of lui, auipc, jal, jalr, br, load, store, op_imm, op_reg, or when inst[1:0] != 2'b11.
  - out_regf_we is forced to 0 for such slots.
- Undefined: out_illegal is tied to 0 and no extra logic is generated.

Test Plan:
- Reset then idle: after rst, occupancy=0, out_valid=0, enq_ready=1; no change over 10 idle cycles.
- Enqueue addi x5,x0,-1 (0xFFF00293) at pc 0x100 -> next cycle out_valid[0]=1, out_pc=0x100, out_rd=5, out_imm=0xFFFFFFFF, out_regf_we=1, out_valid[1]=0.
- Fill to DEPTH=8 with deq_cnt=0 -> enq_ready=0 after 8th fire; 9th enq_valid ignored, occupancy stays 8. Same cycle enq+deq_cnt=1 at count=7 -> count stays 7.
- Wrap: with head=7, enqueue 2 entries, deq_cnt=2 -> slots show entries 7 then 0 in order; head=1.
- Flush while count=5 with enq_valid=1 and deq_cnt=2 -> next cycle occupancy=0, out_valid=0; the enqueued instruction never appears.
- With DECODE_ILLEGAL_EN: enqueue 0x0000000F (fence, unsupported) -> out_illegal[0]=1, out_regf_we[0]=0. Without the macro, out_illegal[0]=0.

Source files
------------

// File: rtl/decode_queue_if.sv
// Fetch/rename handshake bundle for the decode queue: enqueue side, dequeue count,
// flush and the decoded slot outputs packed slot-major (slot i at [i*W +: W]).
interface decode_queue_if #(
   parameter int DEPTH     = 8,
   parameter int DEC_WIDTH = 2
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DCW   = $clog2(DEC_WIDTH + 1);

   logic                    flush;
   logic                    enq_valid;
   logic [31:0]             enq_inst;
   logic [31:0]             enq_pc;
   logic                    enq_ready;
   logic [DCW-1:0]          deq_cnt;
   logic [DEC_WIDTH-1:0]    out_valid;
   logic [32*DEC_WIDTH-1:0] out_pc;
   logic [7*DEC_WIDTH-1:0]  out_opcode;
   logic [3*DEC_WIDTH-1:0]  out_funct3;
   logic [7*DEC_WIDTH-1:0]  out_funct7;
   logic [5*DEC_WIDTH-1:0]  out_rs1;
   logic [5*DEC_WIDTH-1:0]  out_rs2;
   logic [5*DEC_WIDTH-1:0]  out_rd;
   logic [32*DEC_WIDTH-1:0] out_imm;
   logic [DEC_WIDTH-1:0]    out_regf_we;
   logic [DEC_WIDTH-1:0]    out_illegal;
   logic [CNT_W-1:0]        occupancy;

   modport master (
      output flush, enq_valid, enq_inst, enq_pc, deq_cnt,
      input  enq_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
             out_rs1, out_rs2, out_rd, out_imm, out_regf_we, out_illegal, occupancy
   );

   modport slave (
      input  flush, enq_valid, enq_inst, enq_pc, deq_cnt,
      output enq_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
             out_rs1, out_rs2, out_rd, out_imm, out_regf_we, out_illegal, occupancy
   );
endinterface

// File: rtl/decode_queue.sv
// Circular instruction queue presenting up to DEC_WIDTH decoded RV32I slots per cycle.
// Optional illegal-opcode flagging is enabled by defining DECODE_ILLEGAL_EN.
module decode_queue_chk #(
   parameter int DEC_WIDTH = 2,
   parameter int CNT_W     = 4,
   parameter int DCW       = 2
) (
   input logic             clk,
   input logic             rst,
   input logic [CNT_W-1:0] occupancy,
   input logic [DCW-1:0]   deq_cnt
);
   logic [CNT_W-1:0] vis_s;

   assign vis_s = (occupancy > CNT_W'(DEC_WIDTH)) ? CNT_W'(DEC_WIDTH) : occupancy;

   // Rename may only consume slots that are currently presented as valid.
   a_deq_le_valid: assert property (@(posedge clk) disable iff (rst) CNT_W'(deq_cnt) <= vis_s);
endmodule

module decode_queue #(
   parameter int DEPTH     = 8,
   parameter int DEC_WIDTH = 2
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int DCW   = $clog2(DEC_WIDTH + 1);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   function automatic logic [31:0] imm_sel(input logic [31:0] inst);
      logic [31:0] imm;
      case (inst[6:0])
         OP_LUI, OP_AUIPC:        imm = {inst[31:12], 12'h000};
         OP_JAL:                  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         OP_JALR, OP_LOAD, OP_IMM: imm = {{20{inst[31]}}, inst[31:20]};
         OP_BR:                   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_STORE:                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         default:                 imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

   function automatic logic writes_rd(input logic [31:0] inst);
      logic we;
      case (inst[6:0])
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: we = (inst[11:7] != 5'd0);
         default:                                                    we = 1'b0;
      endcase
      return we;
   endfunction

`ifdef DECODE_ILLEGAL_EN
   function automatic logic is_legal(input logic [31:0] inst);
      logic ok;
      case (inst[6:0])
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
         OP_LOAD, OP_STORE, OP_IMM, OP_REG:          ok = (inst[1:0] == 2'b11);
         default:                                    ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   logic [63:0]      mem_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             enq_ready_s;
   logic             enq_fire_s;

   assign enq_ready_s   = (count_r != CNT_W'(DEPTH));
   assign enq_fire_s    = bus.enq_valid && enq_ready_s && !bus.flush;
   assign bus.enq_ready = enq_ready_s;
   assign bus.occupancy = count_r;

   // Head/tail/count bookkeeping; flush outranks enqueue and dequeue.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         head_r  <= head_r + PTR_W'(bus.deq_cnt);
         if (enq_fire_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         count_r <= count_r + CNT_W'(enq_fire_s) - CNT_W'(bus.deq_cnt);
      end
   end

   // Entry storage is never cleared, only overwritten by accepted enqueues.
   always_ff @(posedge clk) begin
      if (enq_fire_s && !rst) begin
         mem_r[tail_r] <= {bus.enq_inst, bus.enq_pc};
      end
   end

   // Decode the oldest DEC_WIDTH entries; invalid slots are forced to zero.
   always_comb begin
      logic [PTR_W-1:0] idx;
      logic [31:0]      inst;
      idx             = '0;
      inst            = 32'h0000_0000;
      bus.out_valid   = '0;
      bus.out_pc      = '0;
      bus.out_opcode  = '0;
      bus.out_funct3  = '0;
      bus.out_funct7  = '0;
      bus.out_rs1     = '0;
      bus.out_rs2     = '0;
      bus.out_rd      = '0;
      bus.out_imm     = '0;
      bus.out_regf_we = '0;
      bus.out_illegal = '0;
      for (int i = 0; i < DEC_WIDTH; i++) begin
         idx  = head_r + PTR_W'(i);
         inst = mem_r[idx][63:32];
         if (CNT_W'(i) < count_r) begin
            bus.out_valid[i]        = 1'b1;
            bus.out_pc[i*32 +: 32]  = mem_r[idx][31:0];
            bus.out_opcode[i*7 +: 7] = inst[6:0];
            bus.out_funct3[i*3 +: 3] = inst[14:12];
            bus.out_funct7[i*7 +: 7] = inst[31:25];
            bus.out_rs1[i*5 +: 5]   = inst[19:15];
            bus.out_rs2[i*5 +: 5]   = inst[24:20];
            bus.out_rd[i*5 +: 5]    = inst[11:7];
            bus.out_imm[i*32 +: 32] = imm_sel(inst);
`ifdef DECODE_ILLEGAL_EN
            bus.out_illegal[i]      = !is_legal(inst);
            bus.out_regf_we[i]      = writes_rd(inst) && is_legal(inst);
`else
            bus.out_regf_we[i]      = writes_rd(inst);
`endif
         end else begin
            bus.out_valid[i] = 1'b0;
         end
      end
   end

   decode_queue_chk #(
      .DEC_WIDTH (DEC_WIDTH),
      .CNT_W     (CNT_W),
      .DCW       (DCW)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .occupancy (count_r),
      .deq_cnt   (bus.deq_cnt)
   );
endmodule
